// File: rtl/ext_dev_buffer.sv
// 12-word external-device buffer feeding DMA; counts down after start, then raises dev_interrupt.
// Latency: dev_interrupt first high TRIGGER_DELAY+1 cycles after the start edge; edata is combinational from offset.
// Backpressure: buffer frozen outside IDLE until dma_done; EXT_DEV_AUTO_REARM_EN re-arms the countdown from DONE.
module ext_dev_buffer #(
  parameter int WORD_SIZE        = 16,
  parameter int MEMORY_BANDWIDTH = 64,
  parameter int BUF_WORDS        = 12,
  parameter int TRIGGER_DELAY    = 200
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        wr_en,
  input  logic [3:0]                  wr_idx,
  input  logic [WORD_SIZE-1:0]        wr_data,
  input  logic                        start,
  input  logic                        int_ack,
  input  logic [1:0]                  offset,
  input  logic                        dma_done,
  output logic [MEMORY_BANDWIDTH-1:0] edata,
  output logic                        dev_interrupt,
  output logic                        busy,
  output logic                        err
);

  typedef enum logic [2:0] {IDLE, COUNT, REQ, XFER, DONE} state_t;

  localparam logic [9:0] RELOAD = 10'(TRIGGER_DELAY - 1);

  state_t               state, state_nxt;
  logic [9:0]           cnt, cnt_nxt;
  logic                 dev_int_nxt;
  logic                 proto_err;
  logic                 idx_ok;
  logic                 wr_ok;
  logic                 start_in_done_ok;
  logic [3:0]           base;
  logic [WORD_SIZE-1:0] mem [BUF_WORDS];

  assign idx_ok = (wr_idx < 4'(BUF_WORDS));
  assign wr_ok  = (state == IDLE) && wr_en && idx_ok;
  assign busy   = (state != IDLE);

`ifdef EXT_DEV_AUTO_REARM_EN
  assign start_in_done_ok = 1'b1;
`else
  assign start_in_done_ok = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dev_int_nxt = dev_interrupt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COUNT;
          cnt_nxt   = RELOAD;
        end
      end
      COUNT: begin
        if (cnt == 10'd0) state_nxt = REQ;
        else              cnt_nxt   = cnt - 10'd1;
      end
      REQ: begin
        // Interrupt rises one cycle after entering REQ, giving TRIGGER_DELAY+1 total latency.
        dev_int_nxt = 1'b1;
        if (int_ack) begin
          state_nxt   = XFER;
          dev_int_nxt = 1'b0;
        end
      end
      XFER: begin
        if (dma_done) state_nxt = DONE;
      end
      DONE: begin
`ifdef EXT_DEV_AUTO_REARM_EN
        state_nxt = COUNT;
        cnt_nxt   = RELOAD;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    proto_err = 1'b0;
    if (wr_en && ((state != IDLE) || !idx_ok))                              proto_err = 1'b1;
    if (start && (state != IDLE) && !((state == DONE) && start_in_done_ok)) proto_err = 1'b1;
    if (int_ack && (state != REQ))                                          proto_err = 1'b1;
    if (dma_done && (state != XFER))                                        proto_err = 1'b1;
    if ((state == XFER) && (offset == 2'd3))                                proto_err = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      cnt           <= 10'd0;
      dev_interrupt <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      dev_interrupt <= dev_int_nxt;
      if (proto_err) err <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < BUF_WORDS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign base = {offset, 2'b00};

  always_comb begin
    edata = '0;
    if (offset != 2'd3)
      edata = {mem[base + 4'd3], mem[base + 4'd2], mem[base + 4'd1], mem[base]};
  end

endmodule

// File: tb/tb_ext_dev_buffer.sv
// Randomized self-checking bench for ext_dev_buffer against an array-based model of the buffer and timing rules.
module tb_ext_dev_buffer;
  localparam int D = 200;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_idx = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        int_ack = 1'b0;
  logic [1:0]  offset = '0;
  logic        dma_done = 1'b0;
  logic [63:0] edata;
  logic        dev_interrupt;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_buf [12];

  ext_dev_buffer #(.TRIGGER_DELAY(D)) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .start(start), .int_ack(int_ack), .offset(offset), .dma_done(dma_done),
    .edata(edata), .dev_interrupt(dev_interrupt), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] exp_edata(input logic [1:0] o);
    logic [63:0] v;
    v = '0;
    if (o != 2'd3)
      for (int w = 0; w < 4; w++) v = v | (64'(exp_buf[4 * int'(o) + w]) << (16 * w));
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 0; start = 0; int_ack = 0; dma_done = 0; offset = 0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    for (int i = 0; i < 12; i++) exp_buf[i] = '0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 12; i++) begin
      wr_en = 1; wr_idx = 4'(i); wr_data = 16'($urandom);
      exp_buf[i] = wr_data;
      step();
    end
    wr_en = 0;
  endtask

  // Starts a transfer and returns the number of edges until dev_interrupt is seen.
  task automatic start_and_wait(output int n);
    start = 1; step(); start = 0;
    n = 0;
    while (n < 2 * D + 10) begin
      step(); n++;
      if (dev_interrupt) break;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (dev_interrupt !== 1'b0) begin bad++; $display("FAIL reset_int: got %b want 0", dev_interrupt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    for (int o = 0; o < 4; o++) begin
      offset = 2'(o); #1;
      total++; if (edata !== 64'd0) begin bad++; $display("FAIL reset_edata%0d: got %h want 0", o, edata); end
    end
    do_reset();
  endtask

  task automatic test_trigger();
    int n, busy_drops;
    load_random();
    start = 1; step(); start = 0;
    n = 0; busy_drops = 0;
    while (n < 2 * D + 10) begin
      step(); n++;
      if (!busy) busy_drops++;
      if (dev_interrupt) break;
    end
    total++; if (n !== D + 1) begin bad++; $display("FAIL trigger_latency: got %0d want %0d", n, D + 1); end
    total++; if (busy_drops !== 0) begin bad++; $display("FAIL trigger_busy: got %0d idle cycles want 0", busy_drops); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL trigger_err: got %b want 0", err); end
  endtask

  task automatic test_hold_ack();
    int drops = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (dev_interrupt !== 1'b1) drops++;
    end
    total++; if (drops !== 0) begin bad++; $display("FAIL hold_int: got %0d drops want 0", drops); end
    int_ack = 1; step(); int_ack = 0;
    total++; if (dev_interrupt !== 1'b0) begin bad++; $display("FAIL ack_int: got %b want 0", dev_interrupt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ack_busy: got %b want 1", busy); end
  endtask

  task automatic test_edata();
    logic [1:0] o;
    for (int k = 0; k < 23; k++) begin
      o = (k < 3) ? 2'(k) : 2'($urandom_range(0, 2));
      offset = o; #1;
      total++; if (edata !== exp_edata(o)) begin bad++; $display("FAIL edata_off%0d: got %h want %h", o, edata, exp_edata(o)); end
      step();
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL edata_err: got %b want 0", err); end
  endtask

  task automatic test_xfer_violations();
    wr_en = 1; wr_idx = 4'd5; wr_data = 16'hFFFF; offset = 2'd1;
    step(); wr_en = 0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL xfer_wr_err: got %b want 1", err); end
    total++; if (edata !== exp_edata(2'd1)) begin bad++; $display("FAIL xfer_wr_buf: got %h want %h", edata, exp_edata(2'd1)); end
    offset = 2'd3; #1;
    total++; if (edata !== 64'd0) begin bad++; $display("FAIL xfer_off3: got %h want 0", edata); end
    step(); offset = 2'd0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL xfer_stay: got %b want 1", busy); end
    dma_done = 1; step(); dma_done = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL done_busy: got %b want 1", busy); end
    step();
`ifndef EXT_DEV_AUTO_REARM_EN
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_idle: got %b want 0", busy); end
`endif
    do_reset();
  endtask

  task automatic test_start_in_count();
    int n;
    load_random();
    start = 1; step(); start = 0;
    n = 0;
    while (n < 2 * D + 10) begin
      if (n == 50) start = 1;
      step(); n++;
      start = 0;
      if (dev_interrupt) break;
    end
    total++; if (n !== D + 1) begin bad++; $display("FAIL count_restart: got %0d want %0d", n, D + 1); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL count_start_err: got %b want 1", err); end
    do_reset();
  endtask

  task automatic test_reset_mid_count();
    load_random();
    start = 1; step(); start = 0;
    for (int i = 0; i < 100; i++) step();
    wr_en = 1; wr_idx = 4'd0; step(); wr_en = 0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL count_wr_err: got %b want 1", err); end
    #2 RESET = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL async_err: got %b want 0", err); end
    total++; if (dev_interrupt !== 1'b0) begin bad++; $display("FAIL async_int: got %b want 0", dev_interrupt); end
    for (int o = 0; o < 3; o++) begin
      offset = 2'(o); #0.5;
      total++; if (edata !== 64'd0) begin bad++; $display("FAIL async_buf%0d: got %h want 0", o, edata); end
    end
    do_reset();
  endtask

  task automatic test_bad_idx_idle();
    logic [1:0] o;
    load_random();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL idle_wr_err: got %b want 0", err); end
    wr_en = 1; wr_idx = 4'($urandom_range(12, 15)); wr_data = 16'($urandom);
    step(); wr_en = 0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_idx_err: got %b want 1", err); end
    for (int k = 0; k < 3; k++) begin
      o = 2'(k); offset = o; #1;
      total++; if (edata !== exp_edata(o)) begin bad++; $display("FAIL bad_idx_buf%0d: got %h want %h", o, edata, exp_edata(o)); end
    end
    do_reset();
  endtask

  task automatic test_back_to_back_rearm();
    int n;
    logic [1:0] o;
    load_random();
    start_and_wait(n);
    total++; if (n !== D + 1) begin bad++; $display("FAIL rearm_first: got %0d want %0d", n, D + 1); end
    int_ack = 1; dma_done = 1; step(); int_ack = 0; dma_done = 0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ack_done_err: got %b want 1", err); end
    total++; if (dev_interrupt !== 1'b0) begin bad++; $display("FAIL ack_done_int: got %b want 0", dev_interrupt); end
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ack_done_xfer: got %b want 1", busy); end
    dma_done = 1; step(); dma_done = 0;
`ifdef EXT_DEV_AUTO_REARM_EN
    start = 1; step(); start = 0;
    n = 0;
    while (n < 2 * D + 10) begin
      step(); n++;
      if (dev_interrupt) break;
    end
    total++; if (n !== D + 1) begin bad++; $display("FAIL rearm_latency: got %0d want %0d", n, D + 1); end
    o = 2'($urandom_range(0, 2)); offset = o; #1;
    total++; if (edata !== exp_edata(o)) begin bad++; $display("FAIL rearm_buf: got %h want %h", edata, exp_edata(o)); end
`else
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (dev_interrupt || busy) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL no_rearm: got %0d active cycles want 0", n); end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_hold_ack();
    test_edata();
    test_xfer_violations();
    test_start_in_count();
    test_reset_mid_count();
    test_bad_idx_idle();
    test_back_to_back_rearm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_dev_buffer.md
Name: ext_dev_buffer

Overview:
- Upstream data source for the DMA stage: a 12-word external-device buffer that the DMA drains into memory in three 4-word (64-bit) blocks.
- The buffer is loaded word by word. On `start`, a trigger countdown runs, then the block raises a device interrupt to the CPU and holds the buffer stable until the DMA reports completion.
- It drives `edata` combinationally from the DMA's block `offset`, so the DMA can gate it straight onto the memory bus.

Parameters:
- WORD_SIZE, 16, width of one buffer word.
- MEMORY_BANDWIDTH, 64, edata width (4 words).
- BUF_WORDS, 12, buffer depth (fixed 3 blocks × 4 words).
- TRIGGER_DELAY, 200, cycles from start acceptance to interrupt assertion; legal range 1..1023.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous reset, active-high.
- wr_en  in  1  buffer load strobe.
- wr_idx  in  4  word index to load (0..11).
- wr_data  in  16  word to load.
- start  in  1  single-cycle pulse: arm the transfer.
- int_ack  in  1  CPU acknowledge of dev_interrupt (same cycle the CPU issues cmd to the DMA).
- offset  in  2  DMA block offset (0..2).
- dma_done  in  1  DMA completion interrupt.
- edata  out  64  selected block.
- dev_interrupt  out  1  request to CPU: buffer ready.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, RESET=1):
  - state=IDLE, counter=0, dev_interrupt=0, busy=0, err=0.
  - Buffer contents cleared to 0.
  - edata follows the combinational rule below.
- edata (combinational):
  - offset o in 0..2: {buf[4o+3], buf[4o+2], buf[4o+1], buf[4o]}; buf[4o] occupies bits [15:0].
  - offset=3: edata=0.
- Buffer writes:
  - Accepted only in IDLE when wr_en=1 and wr_idx<12; the word is written at the CLK edge.
  - wr_en in any other state, or wr_idx≥12, causes no write and sets err.
- FSM (all transitions on the CLK rising edge):
  - IDLE: start=1 → COUNT, counter=TRIGGER_DELAY-1. If wr_en and start arrive in the same cycle, the write lands and COUNT is entered.
  - COUNT: counter decrements each cycle; at counter=0 → REQ and dev_interrupt=1 on the following cycle edge. Interrupt latency from start is exactly TRIGGER_DELAY+1 cycles (start edge to first cycle with dev_interrupt=1).
  - REQ: dev_interrupt held at 1 until int_ack=1 → XFER and dev_interrupt=0.
  - XFER: buffer frozen; waits for dma_done=1 → DONE.
  - DONE: one cycle with busy=1, then → IDLE (or COUNT, see the optional feature).
- Protocol errors (all set err; err clears only on RESET):
  - start outside IDLE: ignored.
  - int_ack outside REQ: ignored.
  - dma_done outside XFER: ignored.
  - offset=3 sampled while in XFER.
- dma_done and int_ack in the same REQ cycle: int_ack is honoured → XFER; dma_done is treated as premature and sets err.
- A RESET pulse mid-transfer returns the block to IDLE immediately and clears the buffer. The DMA is expected to be reset by the same signal.
- Counter width is 10 bits; no wrap-around occurs because the countdown stops at 0.

Optional Feature:
- Macro: EXT_DEV_AUTO_REARM_EN.
- Defined: DONE goes directly to COUNT with counter reloaded to TRIGGER_DELAY-1, so the same buffer contents are re-signalled periodically. A start pulse is not needed and is ignored without error in DONE. Returning to IDLE for reloading requires RESET.
- Undefined: DONE → IDLE; a new start is required for each transfer.

Test Plan:
- Load words 0x0000..0x000B at idx 0..11, pulse start with TRIGGER_DELAY=200 → dev_interrupt rises exactly 201 cycles after the start edge; busy=1 throughout.
- In XFER, drive offset=0,1,2 → edata = 0x0003000200010000, 0x0007000600050004, 0x000B000A00090008; err stays 0.
- Hold off int_ack for 50 cycles → dev_interrupt stays 1. Assert int_ack → dev_interrupt=0 next cycle. Pulse dma_done → DONE for one cycle, then IDLE with busy=0.
- Violations → err=1 and no state or buffer change:
  - wr_en with wr_idx=5 in XFER, data 0xFFFF: buf[5] unchanged.
  - start pulse in COUNT: counter not reloaded.
  - offset=3 in XFER: edata=0 and err=1.
- Assert RESET mid-COUNT (counter≈100) → state IDLE, dev_interrupt=0, buffer all zero, err=0, asynchronously before the next edge.
- With EXT_DEV_AUTO_REARM_EN defined: complete one transfer → dev_interrupt re-asserts 201 cycles after DONE with unchanged buffer data. Undefined: no re-assertion after 1000 cycles.
